ak4619_tdm_rx: RTL and testbench

- Capture stage downstream of the AK4619 codec interface.
- Samples codec BICK/LRCK/SDOUT1 in the 12 MHz system clock domain and deserializes the TDM ADC stream into N_CH parallel signed samples.
- Emits one valid strobe per complete frame and flags malformed frames.
- Feeds the DSP/sample-processing logic; bick/lrck are derived from clk by the codec interface, so no CDC beyond optional input synchronisers.

---
 rtl/ak4619_pkg.sv | 30 +++
 rtl/ak4619_tdm_rx_sync_edge.sv | 41 ++++
 rtl/ak4619_tdm_rx.sv | 152 +++++++++++++++
 tb/tb_ak4619_tdm_rx.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ak4619_pkg.sv
`default_nettype none
//==============================================================================
// Package     : ak4619_pkg
// Description : Shared AK4619 TDM constants, sample type, channel indices and
//               a sizing helper for the frame bit counter.
// Revision    : 1.0 - initial release
//==============================================================================
package ak4619_pkg;

   // Default codec TDM geometry: 4 slots x 32 BICK, 16-bit left-justified data
   localparam int AK_N_CH       = 4;
   localparam int AK_SLOT_BITS  = 32;
   localparam int AK_W          = 16;
   localparam int AK_FRAME_BITS = AK_N_CH * AK_SLOT_BITS;

   typedef logic signed [AK_W-1:0] sample_t;

   // Slot order on SDOUT1 in TDM128 mode
   localparam int CH_ADC1_L = 0;
   localparam int CH_ADC1_R = 1;
   localparam int CH_ADC2_L = 2;
   localparam int CH_ADC2_R = 3;

   // Counter must hold 0 .. frame_bits+1 (the saturation value marks "too long")
   function automatic int cnt_width(input int frame_bits);
      return $clog2(frame_bits + 2);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ak4619_tdm_rx_sync_edge.sv
`default_nettype none
//==============================================================================
// Module      : sync_edge
// Description : Optional synchroniser chain followed by a level register (s1)
//               and an edge register (s2); reports the level and a one-cycle
//               rising-edge pulse.
// Ports       : clk, rst     - clock, asynchronous active-high reset
//               d_i          - raw input
//               level_o      - registered level (s1)
//               rise_o       - s1 & ~s2
// Revision    : 1.0 - initial release
//==============================================================================
module sync_edge #(
   parameter int SYNC_STAGES = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic level_o,
   output logic rise_o
);

   // pipe_q[SYNC_STAGES] is s1, pipe_q[SYNC_STAGES+1] is s2
   logic [SYNC_STAGES+1:0] pipe_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_q <= '0;
      end else begin
         pipe_q[0] <= d_i;
         for (int i = 1; i <= SYNC_STAGES + 1; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign level_o = pipe_q[SYNC_STAGES];
   assign rise_o  = pipe_q[SYNC_STAGES] & ~pipe_q[SYNC_STAGES+1];

endmodule
`default_nettype wire

// File: rtl/ak4619_tdm_rx.sv
`default_nettype none
//==============================================================================
// Module      : ak4619_tdm_rx
// Description : Deserialises the AK4619 TDM ADC stream (BICK/LRCK/SDOUT1,
//               sampled in the clk domain) into N_CH parallel signed samples.
//               One sample_valid pulse per complete frame, frame_err pulse on
//               a frame whose BICK count differs from N_CH*SLOT_BITS.
// Ports       : clk, rst      - system clock, asynchronous active-high reset
//               bick, lrck    - codec bit / frame clocks (clk-synchronous)
//               sdout         - codec ADC serial data
//               samples       - channel c at [c*W +: W]
//               sample_valid  - one-cycle pulse, samples refreshed
//               frame_err     - one-cycle pulse, frame length mismatch
// Revision    : 1.0 - initial release
//==============================================================================
module ak4619_tdm_rx
   import ak4619_pkg::*;
#(
   parameter int N_CH        = AK_N_CH,
   parameter int SLOT_BITS   = AK_SLOT_BITS,
   parameter int W           = AK_W,
   parameter int DELAY       = 1,
   parameter int SYNC_STAGES = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              bick,
   input  logic              lrck,
   input  logic              sdout,
   output logic [N_CH*W-1:0] samples,
   output logic              sample_valid,
   output logic              frame_err
);

   localparam int FRAME_BITS = N_CH * SLOT_BITS;
   localparam int CNT_W      = cnt_width(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);

   // ---------------------------------------------------------------- inputs
   logic w_bick_lvl, w_bick_rise, w_lrck_lvl, w_lrck_rise, w_sd;
   logic w_unused;

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_bick_edge (
      .clk(clk), .rst(rst), .d_i(bick), .level_o(w_bick_lvl), .rise_o(w_bick_rise)
   );

   sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lrck_edge (
      .clk(clk), .rst(rst), .d_i(lrck), .level_o(w_lrck_lvl), .rise_o(w_lrck_rise)
   );

   // Only the edges are needed here; the levels exist for other consumers
   assign w_unused = w_bick_lvl & w_lrck_lvl;

   // sdout gets the same depth as s1 so it lines up with bick_rise
   logic [SYNC_STAGES:0] sd_pipe_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sd_pipe_q <= '0;
      end else begin
         sd_pipe_q[0] <= sdout;
         for (int i = 1; i <= SYNC_STAGES; i++) begin
            sd_pipe_q[i] <= sd_pipe_q[i-1];
         end
      end
   end

   assign w_sd = sd_pipe_q[SYNC_STAGES];

   // ----------------------------------------------------------------- state
   logic [N_CH-1:0][W-1:0] shift_q, shift_d;
   logic [N_CH-1:0][W-1:0] samples_q, samples_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   armed_q, armed_d;
   logic                   valid_pend_q, valid_pend_d;
   logic                   err_pend_q, err_pend_d;
   logic                   sample_valid_q, frame_err_q;

   logic [CNT_W-1:0]       w_pos;   // position of the current bick edge
   int                     w_p;     // position relative to the first MSB

   always_comb begin
      shift_d      = shift_q;
      samples_d    = samples_q;
      cnt_d        = cnt_q;
      armed_d      = armed_q;
      valid_pend_d = 1'b0;
      err_pend_d   = 1'b0;
      w_pos        = cnt_q;
      w_p          = 0;

      // Frame boundary is handled before any coincident bick edge, so that
      // edge becomes position 0 of the new frame.
      if (w_lrck_rise) begin
         if (armed_q) begin
            if (cnt_q == CNT_FULL) begin
               samples_d    = shift_q;
               valid_pend_d = 1'b1;
            end else begin
               err_pend_d   = 1'b1;
            end
         end
         armed_d = 1'b1;
         shift_d = '0;
         w_pos   = '0;
         cnt_d   = '0;
      end

      if (w_bick_rise) begin
         cnt_d = (w_pos == CNT_MAX) ? w_pos : w_pos + CNT_W'(1);
         w_p   = int'(w_pos) - DELAY;
         if (w_p >= 0 && w_p < FRAME_BITS && (w_p % SLOT_BITS) < W) begin
            for (int c = 0; c < N_CH; c++) begin
               if ((w_p / SLOT_BITS) == c) begin
                  shift_d[c] = W'({shift_d[c], w_sd});
               end
            end
         end
      end
   end

   // samples_q updates one cycle ahead of the strobe, so it is already
   // stable when sample_valid is seen.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q        <= '0;
         samples_q      <= '0;
         cnt_q          <= '0;
         armed_q        <= 1'b0;
         valid_pend_q   <= 1'b0;
         err_pend_q     <= 1'b0;
         sample_valid_q <= 1'b0;
         frame_err_q    <= 1'b0;
      end else begin
         shift_q        <= shift_d;
         samples_q      <= samples_d;
         cnt_q          <= cnt_d;
         armed_q        <= armed_d;
         valid_pend_q   <= valid_pend_d;
         err_pend_q     <= err_pend_d;
         sample_valid_q <= valid_pend_q;
         frame_err_q    <= err_pend_q;
      end
   end

   assign samples      = samples_q;
   assign sample_valid = sample_valid_q;
   assign frame_err    = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ak4619_tdm_rx.sv
`default_nettype none
//==============================================================================
// Module      : tb_ak4619_tdm_rx
// Description : Directed self-checking bench for ak4619_tdm_rx. One instance
//               in I2S timing (DELAY=1), one left-justified (DELAY=0) with
//               lrck rising together with bick.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_ak4619_tdm_rx;
   import ak4619_pkg::*;

   logic clk = 1'b0, rst = 1'b1;
   logic bick = 1'b0, lrck = 1'b0, sdout = 1'b0;
   logic bick0 = 1'b0, lrck0 = 1'b0, sdout0 = 1'b0;
   logic [63:0] samples, samples0;
   logic sample_valid, frame_err, sample_valid0, frame_err0;

   int checks = 0, failures = 0;
   int cyc = 0, lrck_cyc = 0;
   int valid_cnt = 0, err_cnt = 0, valid_cyc = -1, err_cyc = -1;
   int valid0_cnt = 0, err0_cnt = 0;

   localparam logic [63:0] DA = 64'hFFFF_7FFF_8000_1234;
   localparam logic [63:0] DB = 64'h0F0F_A5A5_0001_C3C3;
   localparam logic [63:0] DC = 64'h1357_2468_0ACE_BDF0;

   ak4619_tdm_rx #(.N_CH(4), .SLOT_BITS(32), .W(16), .DELAY(1), .SYNC_STAGES(0)) u_dut (
      .clk(clk), .rst(rst), .bick(bick), .lrck(lrck), .sdout(sdout),
      .samples(samples), .sample_valid(sample_valid), .frame_err(frame_err)
   );

   ak4619_tdm_rx #(.N_CH(4), .SLOT_BITS(32), .W(16), .DELAY(0), .SYNC_STAGES(0)) u_dut0 (
      .clk(clk), .rst(rst), .bick(bick0), .lrck(lrck0), .sdout(sdout0),
      .samples(samples0), .sample_valid(sample_valid0), .frame_err(frame_err0)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Pulse counters, sampled away from the active edge
   always @(negedge clk) begin
      if (sample_valid)  begin valid_cnt++; valid_cyc = cyc; end
      if (frame_err)     begin err_cnt++;   err_cyc   = cyc; end
      if (sample_valid0) valid0_cnt++;
      if (frame_err0)    err0_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Bit on the wire for frame position k (bick rising edge index)
   function automatic logic frame_bit(input logic [63:0] d, input int k, input int dly,
                                      input logic tail);
      int p, slot, b;
      p = k - dly;
      if (p < 0 || p >= 128) return 1'b0;
      slot = p / 32;
      b    = p % 32;
      if (b >= 16) return tail;
      return d[slot*16 + 15 - b];
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      bick = 1'b0; lrck = 1'b0; sdout = 1'b0;
      bick0 = 1'b0; lrck0 = 1'b0; sdout0 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // bick = clk/4; data changes on bick fall, lrck rises while bick is low
   task automatic send_frame(input logic [63:0] d, input int nbits, input logic tail);
      for (int k = 0; k < nbits; k++) begin
         @(negedge clk);
         bick  = 1'b0;
         sdout = frame_bit(d, k, 1, tail);
         if (k == 0) begin
            lrck = 1'b1; lrck_cyc = cyc;
         end else if (k == nbits / 2) begin
            lrck = 1'b0;
         end
         repeat (2) @(negedge clk);
         bick = 1'b1;
         @(negedge clk);
      end
   endtask

   task automatic boundary();
      @(negedge clk);
      bick = 1'b0; sdout = 1'b0; lrck = 1'b1; lrck_cyc = cyc;
      repeat (6) @(negedge clk);
   endtask

   // Left-justified variant: lrck and bick rise on the same clk edge
   task automatic send_frame0(input logic [63:0] d, input int nbits);
      for (int k = 0; k < nbits; k++) begin
         @(negedge clk);
         bick0  = 1'b0;
         sdout0 = frame_bit(d, k, 0, 1'b0);
         repeat (2) @(negedge clk);
         bick0 = 1'b1;
         if (k == 0) lrck0 = 1'b1;
         else if (k == nbits / 2) lrck0 = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (samples !== 64'h0) begin failures++; $display("FAIL reset_samples: got %h want %h", samples, 64'h0); end
      checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", sample_valid); end
      checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", frame_err); end
      checks++; if (samples0 !== 64'h0) begin failures++; $display("FAIL reset_samples0: got %h want %h", samples0, 64'h0); end
      rst = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (valid_cnt !== 0 || err_cnt !== 0) begin failures++; $display("FAIL reset_idle: valid=%0d err=%0d want 0/0", valid_cnt, err_cnt); end
   endtask

   task automatic test_frames();
      int v, e;
      do_reset();
      v = valid_cnt; e = err_cnt;
      send_frame(DA, 128, 1'b0);
      checks++; if (valid_cnt !== v) begin failures++; $display("FAIL first_boundary_valid: got %0d want %0d", valid_cnt, v); end
      checks++; if (err_cnt !== e) begin failures++; $display("FAIL first_boundary_err: got %0d want %0d", err_cnt, e); end
      send_frame(DB, 128, 1'b0);
      checks++; if (valid_cnt !== v + 1) begin failures++; $display("FAIL frame1_valid: got %0d want %0d", valid_cnt, v + 1); end
      checks++; if (samples !== DA) begin failures++; $display("FAIL frame1_samples: got %h want %h", samples, DA); end
      checks++; if (valid_cyc !== lrck_cyc + 3) begin failures++; $display("FAIL valid_latency: got cyc %0d want %0d", valid_cyc, lrck_cyc + 3); end
      send_frame(DA, 128, 1'b0);
      checks++; if (samples !== DB) begin failures++; $display("FAIL frame2_samples: got %h want %h", samples, DB); end
      boundary();
      checks++; if (samples !== DA) begin failures++; $display("FAIL frame3_samples: got %h want %h", samples, DA); end
      checks++; if (valid_cnt !== v + 3) begin failures++; $display("FAIL frames_valid_total: got %0d want %0d", valid_cnt, v + 3); end
      checks++; if (err_cnt !== e) begin failures++; $display("FAIL frames_err_total: got %0d want %0d", err_cnt, e); end
   endtask

   task automatic test_tail();
      int v;
      do_reset();
      v = valid_cnt;
      send_frame(DB, 128, 1'b0);
      send_frame(64'h0, 128, 1'b1);
      checks++; if (samples !== DB) begin failures++; $display("FAIL tail_prev_samples: got %h want %h", samples, DB); end
      boundary();
      checks++; if (samples !== 64'h0) begin failures++; $display("FAIL tail_samples: got %h want %h", samples, 64'h0); end
      checks++; if (valid_cnt !== v + 2) begin failures++; $display("FAIL tail_valid: got %0d want %0d", valid_cnt, v + 2); end
   endtask

   task automatic test_short_frame();
      int v, e;
      do_reset();
      send_frame(DA, 128, 1'b0);
      send_frame(DB, 120, 1'b0);
      v = valid_cnt; e = err_cnt;
      send_frame(64'h00AA, 128, 1'b0);
      checks++; if (err_cnt !== e + 1) begin failures++; $display("FAIL short_err: got %0d want %0d", err_cnt, e + 1); end
      checks++; if (err_cyc !== lrck_cyc + 3) begin failures++; $display("FAIL short_err_latency: got cyc %0d want %0d", err_cyc, lrck_cyc + 3); end
      checks++; if (valid_cnt !== v) begin failures++; $display("FAIL short_no_valid: got %0d want %0d", valid_cnt, v); end
      checks++; if (samples !== DA) begin failures++; $display("FAIL short_hold: got %h want %h", samples, DA); end
      boundary();
      checks++; if (valid_cnt !== v + 1) begin failures++; $display("FAIL short_recover_valid: got %0d want %0d", valid_cnt, v + 1); end
      checks++; if (samples !== 64'h00AA) begin failures++; $display("FAIL short_recover_samples: got %h want %h", samples, 64'h00AA); end
      checks++; if (err_cnt !== e + 1) begin failures++; $display("FAIL short_recover_err: got %0d want %0d", err_cnt, e + 1); end
   endtask

   task automatic test_long_frame();
      int v, e;
      do_reset();
      send_frame(DB, 128, 1'b0);
      send_frame(DA, 140, 1'b1);
      v = valid_cnt; e = err_cnt;
      send_frame(DC, 128, 1'b0);
      checks++; if (err_cnt !== e + 1) begin failures++; $display("FAIL long_err: got %0d want %0d", err_cnt, e + 1); end
      checks++; if (valid_cnt !== v) begin failures++; $display("FAIL long_no_valid: got %0d want %0d", valid_cnt, v); end
      checks++; if (samples !== DB) begin failures++; $display("FAIL long_hold: got %h want %h", samples, DB); end
      boundary();
      checks++; if (samples !== DC) begin failures++; $display("FAIL long_recover_samples: got %h want %h", samples, DC); end
      checks++; if (valid_cnt !== v + 1) begin failures++; $display("FAIL long_recover_valid: got %0d want %0d", valid_cnt, v + 1); end
   endtask

   task automatic test_reset_mid_frame();
      int v, e;
      do_reset();
      send_frame(DA, 128, 1'b0);
      send_frame(DB, 128, 1'b0);
      checks++; if (samples !== DA) begin failures++; $display("FAIL mid_pre_samples: got %h want %h", samples, DA); end
      send_frame(DC, 50, 1'b0);
      @(negedge clk);
      rst = 1'b1; bick = 1'b0; lrck = 1'b0; sdout = 1'b0;
      #1;
      checks++; if (samples !== 64'h0) begin failures++; $display("FAIL mid_async_clear: got %h want %h", samples, 64'h0); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      v = valid_cnt; e = err_cnt;
      send_frame(DB, 128, 1'b0);
      checks++; if (valid_cnt !== v || err_cnt !== e) begin failures++; $display("FAIL mid_first_boundary: valid=%0d err=%0d want %0d/%0d", valid_cnt, err_cnt, v, e); end
      send_frame(DC, 128, 1'b0);
      checks++; if (valid_cnt !== v + 1) begin failures++; $display("FAIL mid_next_valid: got %0d want %0d", valid_cnt, v + 1); end
      checks++; if (samples !== DB) begin failures++; $display("FAIL mid_next_samples: got %h want %h", samples, DB); end
   endtask

   task automatic test_delay0_coincident();
      int v, e;
      logic [63:0] d0;
      logic [15:0] ch0;
      d0 = 64'h7E57_0000_FFFF_8001;
      do_reset();
      v = valid0_cnt; e = err0_cnt;
      send_frame0(d0, 128);
      checks++; if (valid0_cnt !== v) begin failures++; $display("FAIL d0_first_boundary: got %0d want %0d", valid0_cnt, v); end
      send_frame0(64'h0, 128);
      ch0 = samples0[CH_ADC1_L*16 +: 16];
      checks++; if (valid0_cnt !== v + 1) begin failures++; $display("FAIL d0_valid: got %0d want %0d", valid0_cnt, v + 1); end
      checks++; if (ch0 !== 16'h8001) begin failures++; $display("FAIL d0_ch0: got %h want %h", ch0, 16'h8001); end
      checks++; if (samples0 !== d0) begin failures++; $display("FAIL d0_samples: got %h want %h", samples0, d0); end
      checks++; if (err0_cnt !== e) begin failures++; $display("FAIL d0_err: got %0d want %0d", err0_cnt, e); end
   endtask

   initial begin
      test_reset();
      test_frames();
      test_tail();
      test_short_frame();
      test_long_frame();
      test_reset_mid_frame();
      test_delay0_coincident();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
